iv_bus_port: RTL



---
 rtl/iv_bus_port.sv | 130 +++++++++++++
 1 files changed

// File: rtl/iv_bus_port.sv
// iv_bus_port: 8x305 IV-bus responder port. Latches the bus address on the
// SC strobe, queues bus writes into a small transmit FIFO, and answers bus
// reads with either the received byte or a status byte.
module iv_bus_port #(
    parameter logic [7:0] PORT_ADDR = 8'h00,
    parameter int         TX_DEPTH  = 4
) (
    input  logic       x1,
    input  logic       reset,
    input  logic [7:0] iv_in,
    output logic [7:0] iv_out,
    output logic       iv_oeb,
    input  logic       bank_n,
    input  logic       sc,
    input  logic       wc,
    input  logic       mclk,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    localparam int          PW        = $clog2(TX_DEPTH);
    localparam int          CW        = 4;
    localparam logic [7:0]  STAT_ADDR = PORT_ADDR + 8'd1;

    logic [7:0]    addr_q, addr_d;
    logic          sel_q, sel_d;
    logic [7:0]    mem_q [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    rx_q, rx_d;
    logic          rx_full_q, rx_full_d;

    // Bus carries inverted data in both directions.
    logic [7:0] bus_val;
    logic       addr_cyc, wr_cyc, rd_cyc, rd_data, rd_stat;
    logic       full, push, pop, ovf_set;
    logic [7:0] status, rd_val;

    assign bus_val  = ~iv_in;
    assign addr_cyc = !bank_n && sc && mclk;
    assign wr_cyc   = !bank_n && !sc && wc && mclk && sel_q && (addr_q == PORT_ADDR);
    // Read is the core's input phase; sel_q clears asynchronously so the
    // drive enable drops at once on reset.
    assign rd_cyc   = reset && !bank_n && !sc && !wc && !mclk && sel_q;
    assign rd_data  = rd_cyc && (addr_q == PORT_ADDR);
    assign rd_stat  = rd_cyc && (addr_q != PORT_ADDR);

    assign full     = (cnt_q == CW'(TX_DEPTH));
    assign tx_valid = (cnt_q != '0);
    assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still accepts a write when the head leaves the same cycle.
    assign push     = wr_cyc && (!full || pop);
    assign ovf_set  = wr_cyc && full && !pop;

    assign rx_ready = !rx_full_q;
    assign status   = {2'b00, ovf_q, cnt_q[2:0], full, rx_full_q};
    assign rd_val   = rd_data ? rx_q : status;
    assign iv_oeb   = !rd_cyc;
    assign iv_out   = rd_cyc ? ~rd_val : 8'hFF;

    // Next-state for address decode, FIFO pointers/count, flags and rx latch.
    always_comb begin
        addr_d    = addr_q;
        sel_d     = sel_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        rx_d      = rx_q;
        rx_full_d = rx_full_q;

        if (addr_cyc) begin
            addr_d = bus_val;
            sel_d  = (bus_val == PORT_ADDR) || (bus_val == STAT_ADDR);
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;

        if (ovf_set)      ovf_d = 1'b1;
        else if (rd_stat) ovf_d = 1'b0;

        // A data read frees the latch; reload waits for rx_ready next cycle.
        if (rx_full_q) begin
            if (rd_data) rx_full_d = 1'b0;
        end else if (rx_valid) begin
            rx_d      = rx_data;
            rx_full_d = 1'b1;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge x1 or negedge reset) begin
        if (!reset) begin
            addr_q    <= 8'h00;
            sel_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            rx_q      <= 8'h00;
            rx_full_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            rx_q      <= rx_d;
            rx_full_q <= rx_full_d;
        end
    end

    // FIFO storage, written at the tail on an accepted push.
    always_ff @(posedge x1 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TX_DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus_val;
        end
    end
endmodule
